sw_debounce_ctrl: RTL and testbench
===================================

SW_DEBOUNCE_CTRL -- requirements
Module: sw_debounce_ctrl

Interface
REQ-001 The block SHALL have parameter N_SW, default 16, meaning the number of switch channels; legal range is 1..32.
REQ-002 The block SHALL have parameter DB_CYCLES, default 100000, meaning the consecutive stable cycles required to accept a change; legal minimum is 1.
REQ-003 The block SHALL have parameter EDGE_MODE, default 0, selecting events: 0 = both edges, 1 = rising only, 2 = falling only.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_i, input, N_SW bits: raw asynchronous switch levels.
REQ-007 The block SHALL have port out_o, output, 32 bits: debounced levels in [N_SW-1:0], with upper bits 0.
REQ-008 The block SHALL have port chg_o, output, 32 bits: sticky per-channel event flags in [N_SW-1:0], with upper bits 0.
REQ-009 The block SHALL have port int_req_o, output, 32 bits: bit 0 is the interrupt request and bits [31:1] are 0.
REQ-010 The block SHALL have port int_fin_i, input, 32 bits: bit 0 is the interrupt-done pulse and bits [31:1] are ignored.
REQ-011 The block SHALL have port error_o, output, 1 bit: sticky overrun flag.

Function
REQ-012 Each channel SHALL pass through a 2-flop synchronizer; the second stage is the synced value s[i].
REQ-013 Each channel SHALL have its own counter of width $clog2(DB_CYCLES+1) and a stable register st[i].
REQ-014 The counter SHALL behave per cycle as follows:
- if s[i]==st[i]: cnt<=0;
- else if cnt==DB_CYCLES-1: st[i]<=s[i] and cnt<=0;
- else cnt<=cnt+1.
REQ-015 Any return of s[i] to st[i] before the count completes SHALL discard the pending change, which is the glitch-rejection behaviour.
REQ-016 out_o[N_SW-1:0] SHALL equal st, registered; a clean input change sampled at edge k SHALL appear on out_o after edge k+1+DB_CYCLES.
REQ-017 An event on channel i SHALL be an update of st[i] qualified by EDGE_MODE (0 = any change, 1 = 0->1, 2 = 1->0).
REQ-018 On any event, the event bits SHALL be OR-ed into chg_o and int_req_o[0] SHALL be set, both visible one edge after st updates.
REQ-019 Events on multiple channels in the same cycle SHALL produce one request with all corresponding chg_o bits set.
REQ-020 On int_fin_i[0]=1 with no event that cycle, int_req_o[0] and chg_o SHALL clear on the next edge.
REQ-021 On int_fin_i[0]=1 coinciding with a new event, the following SHALL hold:
- int_req_o[0] stays 1;
- chg_o is loaded with only the new event bits;
- error_o is unaffected.
REQ-022 An event while int_req_o[0]=1 and int_fin_i[0]=0 SHALL set error_o=1 (sticky), with the event bits still OR-ed into chg_o.
REQ-023 int_fin_i[0] while int_req_o[0]=0 SHALL have no effect.
REQ-024 error_o SHALL clear only on reset.
REQ-025 Counter arithmetic SHALL never wrap; the count saturates by construction at DB_CYCLES-1.

Reset
REQ-026 When rst_i=1 at a clock edge, the following SHALL clear to 0 on that edge, regardless of in-progress counts or pending requests:
- synchronizers, cnt, st;
- out_o, chg_o, int_req_o, error_o.
REQ-027 If in_i is high at reset release, those channels SHALL produce normal debounced events DB_CYCLES+2 edges later.

Verification
REQ-028 Verification SHALL use N_SW=16, DB_CYCLES=4, EDGE_MODE=0 unless stated, and SHALL cover the following scenarios:
- Clean press: in_i[3] 0->1 held -> out_o=0x0008 after edge k+5, int_req_o=1 and chg_o=0x0008 one edge later, error_o=0.
- Glitch: in_i[0] high for 3 cycles then low -> out_o, int_req_o, chg_o remain 0.
- Overrun: event on ch 1, no int_fin, then event on ch 2 -> error_o=1, chg_o=0x0006, int_req_o=1; after int_fin pulse -> int_req_o=0, chg_o=0, error_o stays 1.
- Simultaneous fin and event: int_fin_i[0] pulse on the same edge as a ch 5 event -> int_req_o stays 1, chg_o=0x0020, error_o=0.
- EDGE_MODE=1: ch 7 rises then falls -> only the rise raises int_req_o; out_o tracks both edges.
- Reset mid-debounce: rst_i pulse with cnt=2 and int_req_o=1 -> all outputs 0 next edge; a held input re-debounces the full 4 cycles.

Source files
------------

// File: rtl/sw_debounce_ctrl.sv
// Multi-channel switch debouncer with sticky per-channel change flags and a single
// level interrupt request that software acknowledges with a one-cycle done pulse.
module sw_debounce_ctrl #(
  parameter int N_SW      = 16,
  parameter int DB_CYCLES = 100000,
  parameter int EDGE_MODE = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [N_SW-1:0] in_i,
  output logic [31:0] out_o,
  output logic [31:0] chg_o,
  output logic [31:0] int_req_o,
  input  logic [31:0] int_fin_i,
  output logic        error_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N_SW-1:0] sync1_q, sync2_q;
  logic [N_SW-1:0] st_q, st_d;
  logic [N_SW-1:0] ev_q, ev_d;
  logic [N_SW-1:0] chg_q, chg_d;
  logic [CW-1:0]   cnt_q [N_SW];
  logic [CW-1:0]   cnt_d [N_SW];
  logic            req_q, req_d;
  logic            err_q, err_d;
  logic            fin;
  logic            ev_any;
  logic            unused_fin;

  assign fin        = int_fin_i[0];
  assign unused_fin = ^int_fin_i[31:1];
  assign ev_any     = |ev_q;

  // A pending change is dropped the moment the synced level returns to st.
  always_comb begin
    st_d = st_q;
    ev_d = '0;
    for (int i = 0; i < N_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != st_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          st_d[i] = sync2_q[i];
          case (EDGE_MODE)
            1:       ev_d[i] = sync2_q[i];
            2:       ev_d[i] = ~sync2_q[i];
            default: ev_d[i] = 1'b1;
          endcase
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Handshake: int_req_o[0] is a level held until a cycle with int_fin_i[0]=1;
  // an acknowledge that meets a new event reloads chg with only the new bits,
  // while an event arriving before the acknowledge marks an overrun.
  always_comb begin
    chg_d = chg_q | ev_q;
    req_d = req_q | ev_any;
    err_d = err_q | (req_q & ~fin & ev_any);
    if (req_q && fin) begin
      chg_d = ev_q;
      req_d = ev_any;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      st_q    <= '0;
      ev_q    <= '0;
      chg_q   <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_SW; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      ev_q    <= ev_d;
      chg_q   <= chg_d;
      req_q   <= req_d;
      err_q   <= err_d;
      for (int i = 0; i < N_SW; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_o     = 32'(st_q);
  assign chg_o     = 32'(chg_q);
  assign int_req_o = {31'b0, req_q};
  assign error_o   = err_q;

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Directed bench: one debouncer in both-edge mode (a) and one in rising-only mode (b),
// DB_CYCLES=4, with hand-computed cycle-exact expectations.
module tb_sw_debounce_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] in_a, in_b;
  logic [31:0] fin_a, fin_b;
  logic [31:0] out_a, chg_a, req_a;
  logic [31:0] out_b, chg_b, req_b;
  logic        err_a, err_b;
  int          errors;
  int          checks;

  sw_debounce_ctrl #(.N_SW(16), .DB_CYCLES(4), .EDGE_MODE(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .in_i(in_a), .out_o(out_a), .chg_o(chg_a),
    .int_req_o(req_a), .int_fin_i(fin_a), .error_o(err_a)
  );

  sw_debounce_ctrl #(.N_SW(16), .DB_CYCLES(4), .EDGE_MODE(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .in_i(in_b), .out_o(out_b), .chg_o(chg_b),
    .int_req_o(req_b), .int_fin_i(fin_b), .error_o(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_a();
    fin_a = 32'h1;
    step(1);
    fin_a = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL reset_out_a: got %h exp 0", out_a); end
    checks++; if (chg_a !== 32'h0) begin errors++; $display("FAIL reset_chg_a: got %h exp 0", chg_a); end
    checks++; if (req_a !== 32'h0) begin errors++; $display("FAIL reset_req_a: got %h exp 0", req_a); end
    checks++; if (err_a !== 1'b0)  begin errors++; $display("FAIL reset_err_a: got %b exp 0", err_a); end
    checks++; if (out_b !== 32'h0 || req_b !== 32'h0) begin errors++; $display("FAIL reset_b: out %h req %h exp 0", out_b, req_b); end
    rst = 1'b0;
    fin_a = 32'h1;
    step(1);
    fin_a = 32'h0;
    checks++; if (req_a !== 32'h0 || chg_a !== 32'h0) begin errors++; $display("FAIL idle_fin: req %h chg %h exp 0", req_a, chg_a); end
  endtask

  task automatic test_press();
    in_a[3] = 1'b1;
    step(5);
    checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL press_early: got %h exp 0", out_a); end
    step(1);
    checks++; if (out_a !== 32'h8) begin errors++; $display("FAIL press_out: got %h exp 8", out_a); end
    checks++; if (req_a !== 32'h0) begin errors++; $display("FAIL press_req_early: got %h exp 0", req_a); end
    step(1);
    checks++; if (req_a !== 32'h1) begin errors++; $display("FAIL press_req: got %h exp 1", req_a); end
    checks++; if (chg_a !== 32'h8) begin errors++; $display("FAIL press_chg: got %h exp 8", chg_a); end
    checks++; if (err_a !== 1'b0)  begin errors++; $display("FAIL press_err: got %b exp 0", err_a); end
    fin_a = 32'hFFFF_FFFE;
    step(1);
    fin_a = 32'h0;
    checks++; if (req_a !== 32'h1) begin errors++; $display("FAIL fin_upper_ignored: got %h exp 1", req_a); end
    ack_a();
    checks++; if (req_a !== 32'h0 || chg_a !== 32'h0) begin errors++; $display("FAIL press_ack: req %h chg %h exp 0", req_a, chg_a); end
    in_a[3] = 1'b0;
    step(7);
    checks++; if (out_a !== 32'h0 || chg_a !== 32'h8 || req_a !== 32'h1) begin errors++; $display("FAIL release: out %h chg %h req %h exp 0/8/1", out_a, chg_a, req_a); end
    ack_a();
  endtask

  task automatic test_glitch();
    in_a[0] = 1'b1;
    step(3);
    in_a[0] = 1'b0;
    step(10);
    checks++; if (out_a !== 32'h0) begin errors++; $display("FAIL glitch_out: got %h exp 0", out_a); end
    checks++; if (req_a !== 32'h0) begin errors++; $display("FAIL glitch_req: got %h exp 0", req_a); end
    checks++; if (chg_a !== 32'h0) begin errors++; $display("FAIL glitch_chg: got %h exp 0", chg_a); end
  endtask

  task automatic test_overrun();
    in_a[1] = 1'b1;
    step(7);
    checks++; if (req_a !== 32'h1 || chg_a !== 32'h2 || err_a !== 1'b0) begin errors++; $display("FAIL ovr_first: req %h chg %h err %b exp 1/2/0", req_a, chg_a, err_a); end
    in_a[2] = 1'b1;
    step(7);
    checks++; if (err_a !== 1'b1)  begin errors++; $display("FAIL ovr_err: got %b exp 1", err_a); end
    checks++; if (chg_a !== 32'h6) begin errors++; $display("FAIL ovr_chg: got %h exp 6", chg_a); end
    checks++; if (req_a !== 32'h1) begin errors++; $display("FAIL ovr_req: got %h exp 1", req_a); end
    ack_a();
    checks++; if (req_a !== 32'h0 || chg_a !== 32'h0) begin errors++; $display("FAIL ovr_ack: req %h chg %h exp 0", req_a, chg_a); end
    checks++; if (err_a !== 1'b1)  begin errors++; $display("FAIL ovr_sticky: got %b exp 1", err_a); end
    in_a = '0;
    do_reset();
    checks++; if (err_a !== 1'b0)  begin errors++; $display("FAIL ovr_reset_err: got %b exp 0", err_a); end
  endtask

  task automatic test_fin_and_event();
    in_a[4] = 1'b1;
    step(7);
    checks++; if (req_a !== 32'h1 || chg_a !== 32'h10) begin errors++; $display("FAIL sim_pre: req %h chg %h exp 1/10", req_a, chg_a); end
    in_a[5] = 1'b1;
    step(6);
    fin_a = 32'h1;
    step(1);
    fin_a = 32'h0;
    checks++; if (req_a !== 32'h1)  begin errors++; $display("FAIL sim_req: got %h exp 1", req_a); end
    checks++; if (chg_a !== 32'h20) begin errors++; $display("FAIL sim_chg: got %h exp 20", chg_a); end
    checks++; if (err_a !== 1'b0)   begin errors++; $display("FAIL sim_err: got %b exp 0", err_a); end
    ack_a();
    in_a = '0;
    do_reset();
  endtask

  task automatic test_edge_rise();
    in_b[7] = 1'b1;
    step(6);
    checks++; if (out_b !== 32'h80) begin errors++; $display("FAIL rise_out: got %h exp 80", out_b); end
    step(1);
    checks++; if (req_b !== 32'h1 || chg_b !== 32'h80) begin errors++; $display("FAIL rise_req: req %h chg %h exp 1/80", req_b, chg_b); end
    fin_b = 32'h1;
    step(1);
    fin_b = 32'h0;
    in_b[7] = 1'b0;
    step(6);
    checks++; if (out_b !== 32'h0) begin errors++; $display("FAIL fall_out: got %h exp 0", out_b); end
    step(3);
    checks++; if (req_b !== 32'h0 || chg_b !== 32'h0) begin errors++; $display("FAIL fall_noevent: req %h chg %h exp 0", req_b, chg_b); end
  endtask

  task automatic test_reset_mid();
    in_a[6] = 1'b1;
    step(7);
    checks++; if (req_a !== 32'h1) begin errors++; $display("FAIL mid_pre_req: got %h exp 1", req_a); end
    in_a[8] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    checks++; if (out_a !== 32'h0 || chg_a !== 32'h0 || req_a !== 32'h0 || err_a !== 1'b0) begin errors++; $display("FAIL mid_reset: out %h chg %h req %h err %b exp 0", out_a, chg_a, req_a, err_a); end
    rst = 1'b0;
    step(5);
    checks++; if (out_a !== 32'h0)   begin errors++; $display("FAIL mid_early: got %h exp 0", out_a); end
    step(1);
    checks++; if (out_a !== 32'h140) begin errors++; $display("FAIL mid_out: got %h exp 140", out_a); end
    step(1);
    checks++; if (req_a !== 32'h1 || chg_a !== 32'h140 || err_a !== 1'b0) begin errors++; $display("FAIL mid_event: req %h chg %h err %b exp 1/140/0", req_a, chg_a, err_a); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    in_a   = '0;
    in_b   = '0;
    fin_a  = '0;
    fin_b  = '0;
    test_reset();
    test_press();
    test_glitch();
    test_overrun();
    test_fin_and_event();
    test_edge_rise();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
